trojan_response_checker: RTL
============================

// Module: trojan_response_checker
// PURPOSE
//  Consumes the (input vector, observed response) record stream produced by the benchmark
//  stimulus sweep and checks every record against a golden truth table. Counts mismatches,
//  latches the first failing vector, tracks vector coverage and reports pass/fail.
//  Sits downstream of the exhaustive-sweep driver in the trojan-detection flow.
// PARAMETERS
//  N_IN    3   input-vector width; golden table depth = 2**N_IN
//  N_OUT   1   response width per record
//  CNT_W   8   mismatch-counter width (saturating)
// PORTS
//  CK            in   1       clock, rising edge
//  reset         in   1       asynchronous, active-low reset
//  gold_we       in   1       golden-table write strobe (accepted only in IDLE)
//  gold_addr     in   N_IN    golden-table address (= input vector)
//  gold_data     in   N_OUT   expected response for gold_addr
//  start         in   1       1-cycle pulse: clear results, enter RUN
//  rec_valid     in   1       record valid
//  rec_ready     out  1       checker can accept record
//  rec_vec       in   N_IN    stimulus vector N of record
//  rec_resp      in   N_OUT   observed DUT output of record
//  rec_last      in   1       final record of sweep
//  busy          out  1       state is RUN or FLUSH
//  done          out  1       state is DONE (level)
//  pass          out  1       done && no mismatches && coverage_full
//  mismatch_cnt  out  CNT_W   mismatching records, saturates at all-ones
//  fail_valid    out  1       at least one mismatch captured
//  fail_vec      out  N_IN    vector of first mismatch
//  coverage_full out  1       every vector 0..2**N_IN-1 seen at least once
// BEHAVIOUR
//  - Reset (async, reset=0): state IDLE; all outputs 0; coverage bitmap cleared; golden table
//    contents undefined (not reset).
//  - FSM: IDLE -start-> RUN; RUN -accepted record with rec_last-> FLUSH; FLUSH -> DONE (1 cycle);
//    DONE -start-> RUN. start in RUN/FLUSH ignored.
//  - start: clears mismatch_cnt, fail_valid, fail_vec, coverage bitmap, done/pass next cycle.
//  - rec_ready = 1 only in RUN. Record accepted when rec_valid && rec_ready.
//  - Pipeline: stage 1 registers vec/resp + golden lookup; stage 2 compares and updates results.
//    Results reflect an accepted record 2 cycles after acceptance; FLUSH drains stage 2 so done
//    rises with final counts already valid.
//  - Mismatch: rec_resp != gold[rec_vec]. mismatch_cnt += 1, saturating; first mismatch only
//    sets fail_valid=1 and fail_vec; later mismatches leave fail_vec unchanged.
//  - Coverage: bit rec_vec set per accepted record; duplicates allowed and each is checked.
//  - gold_we outside IDLE ignored; gold_we and start in same IDLE cycle: write occurs, then RUN.
//  - reset asserted mid-RUN: immediate return to IDLE, partial results discarded.
// CONFIGURATION
//  CHECKER_MISR_EN defined: adds output sig [N_IN+N_OUT-1:0]. MISR (Galois, fixed taps in
//    package) folds {rec_vec,rec_resp} per accepted record in stage 2. Cleared by reset/start.
//    Frozen in DONE.
//  Not defined: no sig port, no MISR logic; all other behaviour identical.
// STRUCTURE
//  Package trojan_chk_pkg: state_e {IDLE,RUN,FLUSH,DONE}, MISR tap constants,
//    record struct {vec,resp}.
//  Sub-module golden_table: 2**N_IN x N_OUT register file, 1 write port, 1 registered read port.
// TESTING (N_IN=3, N_OUT=1)
//  1 Load gold=8'b1001_0110 (addr0 LSB); start; stream 000..111 with matching resp, last on 111
//    -> done=1, pass=1, mismatch_cnt=0, coverage_full=1.
//  2 Same, resp flipped for 011 and 110 -> mismatch_cnt=2, fail_valid=1, fail_vec=3'b011, pass=0.
//  3 Stream only 000..101, last on 101, all match -> coverage_full=0, pass=0, mismatch_cnt=0.
//  4 rec_valid held high, gaps in rec_valid, start pulsed mid-RUN and gold_we in RUN
//    -> start and writes ignored; rec_ready=0 in IDLE/FLUSH/DONE; no record lost or duplicated.
//  5 CNT_W=2, 5 mismatching records -> mismatch_cnt saturates at 2'b11.
//  6 reset=0 after 4 records mid-RUN -> all outputs 0 same cycle, state IDLE; new start
//    + full sweep -> clean pass (with CHECKER_MISR_EN: sig equals model value).

Source files
------------

// File: rtl/trojan_chk_pkg.sv
// rtl/trojan_chk_pkg.sv - shared types and MISR taps for the trojan response checker
package trojan_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Galois feedback taps, LSB-aligned; the low N_IN+N_OUT bits are used (x^4 + x^3 + 1 for 4 bits)
    localparam logic [31:0] MISR_TAPS = 32'h0000_0009;

    localparam int REC_VEC_W  = 3;
    localparam int REC_RESP_W = 1;

    typedef struct packed {
        logic [REC_VEC_W-1:0]  vec;
        logic [REC_RESP_W-1:0] resp;
    } record_t;

endpackage

// File: rtl/trojan_response_checker_golden_table.sv
// rtl/trojan_response_checker_golden_table.sv - golden truth table, one write port, one registered read port
module golden_table #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [N_IN-1:0]  i_waddr,
    input  logic [N_OUT-1:0] i_wdata,
    input  logic             i_re,
    input  logic [N_IN-1:0]  i_raddr,
    output logic [N_OUT-1:0] o_rdata
);

    logic [N_OUT-1:0] r_mem [2**N_IN];

    // Contents are deliberately left unreset; the read register only moves on an accepted record
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/trojan_response_checker.sv
// rtl/trojan_response_checker.sv - checks sweep records against a golden table; optional MISR via CHECKER_MISR_EN
module trojan_response_checker
    import trojan_chk_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1,
    parameter int CNT_W = 8
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             gold_we,
    input  logic [N_IN-1:0]  gold_addr,
    input  logic [N_OUT-1:0] gold_data,
    input  logic             start,
    input  logic             rec_valid,
    output logic             rec_ready,
    input  logic [N_IN-1:0]  rec_vec,
    input  logic [N_OUT-1:0] rec_resp,
    input  logic             rec_last,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             fail_valid,
    output logic [N_IN-1:0]  fail_vec,
`ifdef CHECKER_MISR_EN
    output logic [N_IN+N_OUT-1:0] sig,
`endif
    output logic             coverage_full
);

    state_e           r_state;
    state_e           w_next;
    logic             w_accept;
    logic             w_start;
    logic             w_mis;
    logic [N_OUT-1:0] w_gold;
    logic             r_s1_valid;
    logic [N_IN-1:0]  r_s1_vec;
    logic [N_OUT-1:0] r_s1_resp;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fail_valid;
    logic [N_IN-1:0]  r_fail_vec;
    logic [2**N_IN-1:0] r_cov;

    assign w_accept = rec_valid && (r_state == RUN);
    assign w_start  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_mis    = r_s1_valid && (r_s1_resp != w_gold);

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_accept && rec_last) w_next = FLUSH;
            FLUSH:   w_next = DONE;
            DONE:    if (start) w_next = RUN;
            default: w_next = IDLE;
        endcase
    end

    golden_table #(.N_IN(N_IN), .N_OUT(N_OUT)) u_gold (
        .i_clk   (CK),
        .i_we    (gold_we && (r_state == IDLE)),
        .i_waddr (gold_addr),
        .i_wdata (gold_data),
        .i_re    (w_accept),
        .i_raddr (rec_vec),
        .o_rdata (w_gold)
    );

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_vec   <= '0;
            r_s1_resp  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_vec  <= rec_vec;
                r_s1_resp <= rec_resp;
            end
        end
    end

    // Stage 2: the pipeline is always empty when start is honoured, so clearing never drops a record
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
            r_cov        <= '0;
        end else if (w_start) begin
            r_cnt        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
            r_cov        <= '0;
        end else if (r_s1_valid) begin
            r_cov[r_s1_vec] <= 1'b1;
            if (w_mis) begin
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (!r_fail_valid) begin
                    r_fail_valid <= 1'b1;
                    r_fail_vec   <= r_s1_vec;
                end
            end
        end
    end

`ifdef CHECKER_MISR_EN
    localparam int SW = N_IN + N_OUT;
    logic [SW-1:0] r_sig;
    logic [SW-1:0] w_fb;

    assign w_fb = r_sig[SW-1] ? MISR_TAPS[SW-1:0] : '0;

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_sig <= '0;
        end else if (w_start) begin
            r_sig <= '0;
        end else if (r_s1_valid) begin
            r_sig <= {r_sig[SW-2:0], 1'b0} ^ w_fb ^ {r_s1_vec, r_s1_resp};
        end
    end

    assign sig = r_sig;
`endif

    assign rec_ready     = (r_state == RUN);
    assign busy          = (r_state == RUN) || (r_state == FLUSH);
    assign done          = (r_state == DONE);
    assign mismatch_cnt  = r_cnt;
    assign fail_valid    = r_fail_valid;
    assign fail_vec      = r_fail_vec;
    assign coverage_full = &r_cov;
    assign pass          = done && (r_cnt == '0) && coverage_full;

endmodule
